// File: rtl/serial_mag_comp.sv
// serial_mag_comp: bit-serial unsigned magnitude comparator.
// Operands are latched on start and examined one bit pair per clock, MSB
// first. The first differing pair decides the result and ends the
// comparison early. If all pairs match, the operands are equal.
//
// Handshake: start is sampled only while busy=0, including the cycle where
// done=1, so back-to-back requests need no idle cycle. A start seen while
// busy=1 is dropped, not queued. done is a one-cycle pulse that coincides
// with busy=0. The result flags change only on the edge that raises done.
module serial_mag_comp #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             A_gt_B,
    output logic             A_lt_B,
    output logic             A_eq_B,
    output logic             dbg_state_o
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        COMPARE = 1'b1
    } state_t;

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             done_q;
    logic             gt_q;
    logic             lt_q;
    logic             eq_q;

    logic             a_bit;
    logic             b_bit;

    // Select the bit pair currently under examination.
    always_comb begin
        a_bit = a_q[idx_q];
        b_bit = b_q[idx_q];
    end

    // Control FSM, operand latches, bit index and registered result flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= IDX_TOP;
            a_q     <= '0;
            b_q     <= '0;
            done_q  <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= A;
                        b_q     <= B;
                        idx_q   <= IDX_TOP;
                        state_q <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (a_bit != b_bit) begin
                        // The first differing bit from the top decides.
                        gt_q    <= a_bit & ~b_bit;
                        lt_q    <= ~a_bit & b_bit;
                        eq_q    <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else if (idx_q == '0) begin
                        // Every bit pair matched, so the operands are equal.
                        gt_q    <= 1'b0;
                        lt_q    <= 1'b0;
                        eq_q    <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        idx_q <= idx_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Drive the outputs straight from registers.
    always_comb begin
        busy        = (state_q == COMPARE);
        done        = done_q;
        A_gt_B      = gt_q;
        A_lt_B      = lt_q;
        A_eq_B      = eq_q;
        dbg_state_o = state_q;
    end

endmodule

// File: tb/tb_serial_mag_comp.sv
// tb_serial_mag_comp: directed vector table plus hand-written sequences for
// back-to-back starts, ignored inputs while busy and mid-operation reset.
module tb_serial_mag_comp;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic             A_gt_B;
    logic             A_lt_B;
    logic             A_eq_B;
    logic             dbg_state_o;

    int checks;
    int errors;

    serial_mag_comp #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .A          (A),
        .B          (B),
        .busy       (busy),
        .done       (done),
        .A_gt_B     (A_gt_B),
        .A_lt_B     (A_lt_B),
        .A_eq_B     (A_eq_B),
        .dbg_state_o(dbg_state_o)
    );

    // Clock: 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             gt;
        logic             lt;
        logic             eq;
        int               lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at a negedge: present a start, let one edge accept it, drop start.
    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        A     = a;
        B     = b;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
    endtask

    // Count edges after acceptance until done shows up, bounded.
    task automatic wait_done(output int lat);
        lat = 0;
        while (lat < WIDTH + 6) begin
            @(negedge clk);
            lat++;
            if (done) break;
        end
        check("done_seen", {31'd0, done}, 32'd1);
        check("busy_low_at_done", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_flags(input string tag, input logic gt, input logic lt, input logic eq);
        check({tag, "_gt"}, {31'd0, A_gt_B}, {31'd0, gt});
        check({tag, "_lt"}, {31'd0, A_lt_B}, {31'd0, lt});
        check({tag, "_eq"}, {31'd0, A_eq_B}, {31'd0, eq});
    endtask

    // Watch n cycles: no done pulse and no activity may appear.
    task automatic expect_quiet(input string tag, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        check({tag, "_quiet"}, seen, 0);
    endtask

    initial begin
        int lat;
        checks = 0;
        errors = 0;

        // Latency is WIDTH - i for highest differing bit i, WIDTH when equal.
        vecs[0] = '{8'hA5, 8'h25, 1'b1, 1'b0, 1'b0, 1};
        vecs[1] = '{8'h3C, 8'h3D, 1'b0, 1'b1, 1'b0, 8};
        vecs[2] = '{8'h5A, 8'h5A, 1'b0, 1'b0, 1'b1, 8};
        vecs[3] = '{8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 8};
        vecs[4] = '{8'h00, 8'hFF, 1'b0, 1'b1, 1'b0, 1};
        vecs[5] = '{8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, 1};
        vecs[6] = '{8'h12, 8'h16, 1'b0, 1'b1, 1'b0, 6};
        vecs[7] = '{8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, 8};
        vecs[8] = '{8'hF0, 8'hF8, 1'b0, 1'b1, 1'b0, 5};
        vecs[9] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8};

        // Reset held three cycles.
        rst_n = 1'b0;
        start = 1'b0;
        A     = '0;
        B     = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_state", {31'd0, dbg_state_o}, 32'd0);
        check_flags("rst", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        expect_quiet("post_rst", 4);
        check_flags("post_rst", 1'b0, 1'b0, 1'b0);

        // Table of single comparisons.
        for (int i = 0; i < 10; i++) begin
            start_op(vecs[i].a, vecs[i].b);
            check("state_compare", {31'd0, dbg_state_o}, 32'd1);
            wait_done(lat);
            check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
            check_flags($sformatf("v%0d", i), vecs[i].gt, vecs[i].lt, vecs[i].eq);
            @(negedge clk);
            check($sformatf("v%0d_done_one_cycle", i), {31'd0, done}, 32'd0);
            check_flags($sformatf("v%0d_hold", i), vecs[i].gt, vecs[i].lt, vecs[i].eq);
        end

        // Back-to-back: restart in the done cycle.
        start_op(8'h5A, 8'h5A);
        wait_done(lat);
        check("b2b_first_lat", lat, 8);
        check_flags("b2b_first", 1'b0, 1'b0, 1'b1);
        start_op(8'h01, 8'h00);
        check_flags("b2b_hold_during", 1'b0, 1'b0, 1'b1);
        wait_done(lat);
        check("b2b_second_lat", lat, 8);
        check_flags("b2b_second", 1'b1, 1'b0, 1'b0);

        // Inputs and start while busy are ignored.
        @(negedge clk);
        start_op(8'h10, 8'h20);
        @(negedge clk);
        A     = 8'hFF;
        B     = 8'h00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        check("ign_lat", lat, 1);
        check_flags("ign", 1'b0, 1'b1, 1'b0);
        expect_quiet("ign_no_second", 12);
        check_flags("ign_hold", 1'b0, 1'b1, 1'b0);

        // Mid-operation reset: earlier result is lt, must clear at once.
        start_op(8'h00, 8'h01);
        repeat (2) @(negedge clk);
        check("midrst_busy_before", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check_flags("midrst", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        expect_quiet("midrst_after", 12);
        check_flags("midrst_after", 1'b0, 1'b0, 1'b0);

        // Recovery after reset.
        start_op(8'hC3, 8'hC1);
        wait_done(lat);
        check("recover_lat", lat, 7);
        check_flags("recover", 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/serial_mag_comp.md
SERIAL_MAG_COMP -- requirements
Module: serial_mag_comp

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal values are 2 to 32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: a request to compare the current A and B.
REQ-005 The block SHALL have port A, input, WIDTH bits: unsigned operand A.
REQ-006 The block SHALL have port B, input, WIDTH bits: unsigned operand B.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a comparison is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: a one-cycle pulse marking that the result outputs have just updated.
REQ-009 The block SHALL have port A_gt_B, output, 1 bit: registered result, A > B.
REQ-010 The block SHALL have port A_lt_B, output, 1 bit: registered result, A < B.
REQ-011 The block SHALL have port A_eq_B, output, 1 bit: registered result, A == B.

Function
REQ-012 The FSM SHALL have two states.
- IDLE: busy=0.
- COMPARE: busy=1.
REQ-013 In IDLE, start=1 at a rising edge SHALL:
- latch A and B into internal registers;
- load bit index idx=WIDTH-1;
- enter COMPARE.
REQ-014 In IDLE with start=0, the FSM SHALL remain in IDLE.
REQ-015 In COMPARE, each rising edge SHALL examine exactly one bit pair, latched A[idx] vs latched B[idx], MSB first.
REQ-016 In COMPARE, a mismatch at idx SHALL, on that edge:
- set A_gt_B=A[idx]&~B[idx];
- set A_lt_B=~A[idx]&B[idx];
- clear A_eq_B;
- assert done;
- return to IDLE (early termination).
REQ-017 In COMPARE, a match at idx=0 SHALL, on that edge:
- set A_eq_B=1;
- clear A_gt_B and A_lt_B;
- assert done;
- return to IDLE.
REQ-018 In COMPARE, a match at idx>0 SHALL decrement idx and stay in COMPARE; idx SHALL never wrap below 0.
REQ-019 Latency from the edge that accepts start to the edge that raises done SHALL be WIDTH-i cycles when i is the highest differing bit, and WIDTH cycles when the operands are equal; minimum 1, maximum WIDTH.
REQ-020 done SHALL be high for exactly one cycle per accepted start and SHALL coincide with busy=0.
REQ-021 A_gt_B, A_lt_B and A_eq_B SHALL hold their last values through IDLE and through a following COMPARE, changing only on a done edge.
REQ-022 After the first completion, exactly one of A_gt_B, A_lt_B and A_eq_B SHALL be high.
REQ-023 start while busy=1 SHALL be ignored and not queued.
REQ-024 Changes on A and B while busy=1 SHALL NOT affect the comparison in progress.
REQ-025 start=1 in the cycle where done=1 (FSM already in IDLE) SHALL be accepted, allowing back-to-back comparisons with no dead cycle.

Reset
REQ-026 While rst_n=0, asynchronously and regardless of clk, the block SHALL force:
- state=IDLE;
- busy=0, done=0;
- A_gt_B=0, A_lt_B=0, A_eq_B=0;
- idx=WIDTH-1;
- latched operands=0.
REQ-027 Reset asserted mid-COMPARE SHALL abort the comparison, with no done pulse, before or after deassertion.
REQ-028 After rst_n rises, the first rising edge SHALL behave as IDLE.

Verification (WIDTH=8)
REQ-029 Reset: rst_n=0 held 3 cycles -> busy, done, A_gt_B, A_lt_B and A_eq_B all 0; they stay 0 with start=0 after release.
REQ-030 MSB decide: A=8'hA5, B=8'h25, start pulse -> done 1 cycle after acceptance, A_gt_B=1, A_lt_B=0, A_eq_B=0.
REQ-031 LSB decide: A=8'h3C, B=8'h3D -> busy high 8 cycles, done on 8th edge, A_lt_B=1.
REQ-032 Equal operands and back-to-back: A=B=8'h5A -> done after 8 cycles with A_eq_B=1; start=1 in the done cycle with A=8'h01, B=8'h00 -> second done 8 cycles later, A_gt_B=1.
REQ-033 Ignored inputs: A=8'h10, B=8'h20 accepted; 2 cycles later drive A=8'hFF, B=8'h00 and pulse start -> single done, A_lt_B=1, no second comparison.
REQ-034 Mid-op reset: A=8'h00, B=8'h01 accepted; rst_n=0 after 3 cycles -> outputs 0 immediately, no done pulse ever appears for that request.
